// File: rtl/matmul_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : matmul_stream_ctrl_if
// Description : Bundle of the operand stream, multiplier-array and result
//               stream signals of matmul_stream_ctrl. The controller uses
//               the master modport; the surrounding environment uses slave.
// Revision    : 1.0  initial release
// ============================================================================
interface matmul_stream_ctrl_if #(
    parameter int BitWidth = 8
);
    // Operand stream
    logic                    in_valid;
    logic                    in_ready;
    logic [BitWidth-1:0]     in_data;

    // Multiplier array
    logic                    mm_enable;
    logic [9*BitWidth-1:0]   mm_a;
    logic [9*BitWidth-1:0]   mm_b;
    logic [18*BitWidth-1:0]  mm_c;

    // Result stream
    logic                    out_valid;
    logic                    out_ready;
    logic [2*BitWidth-1:0]   out_data;
    logic                    out_last;

    // Status
    logic                    busy;

    modport master (
        input  in_valid, in_data, mm_c, out_ready,
        output in_ready, mm_enable, mm_a, mm_b,
        output out_valid, out_data, out_last, busy
    );

    modport slave (
        output in_valid, in_data, mm_c, out_ready,
        input  in_ready, mm_enable, mm_a, mm_b,
        input  out_valid, out_data, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/matmul_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matmul_stream_ctrl
// Description : Streaming controller for a 3x3 matrix multiplier array.
//               Collects 18 operand beats (A then B, row-major), enables the
//               array for LATENCY cycles, captures the nine products and
//               streams them out C00..C22 with a last marker.
// Revision    : 1.0  initial release
// ============================================================================
module matmul_stream_ctrl #(
    parameter int BitWidth = 8,
    parameter int LATENCY  = 8
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    matmul_stream_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    localparam int         c_DW        = 2 * BitWidth;
    localparam logic [4:0] c_LAST_BEAT = 5'd17;
    localparam logic [4:0] c_B_BASE    = 5'd9;
    localparam logic [7:0] c_LAST_CYC  = 8'(LATENCY - 1);
    localparam logic [3:0] c_LAST_IDX  = 4'd8;

    state_t              r_state;
    logic [4:0]          r_beat;
    logic [7:0]          r_cyc;
    logic [3:0]          r_idx;

    logic [BitWidth-1:0] r_a   [9];
    logic [BitWidth-1:0] r_b   [9];
    logic [c_DW-1:0]     r_res [9];

    logic                r_in_ready;
    logic                r_mm_enable;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_busy;
    logic [c_DW-1:0]     r_out_data;

    logic [c_DW-1:0]     w_c [9];
    logic                w_in_fire;
    logic                w_out_fire;
    logic [3:0]          w_idx_nxt;

    assign w_in_fire  = bus.in_valid  & r_in_ready;
    assign w_out_fire = r_out_valid   & bus.out_ready;
    assign w_idx_nxt  = r_idx + 4'd1;

    // Operand registers drive the array directly; product lanes are unpacked
    generate
        for (genvar k = 0; k < 9; k++) begin : g_elem
            assign bus.mm_a[k*BitWidth +: BitWidth] = r_a[k];
            assign bus.mm_b[k*BitWidth +: BitWidth] = r_b[k];
            assign w_c[k] = bus.mm_c[k*c_DW +: c_DW];
        end
    endgenerate

    assign bus.in_ready  = r_in_ready;
    assign bus.mm_enable = r_mm_enable;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;

    // Load/compute/drain sequencer with all handshake outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_LOAD;
            r_beat      <= 5'd0;
            r_cyc       <= 8'd0;
            r_idx       <= 4'd0;
            for (int k = 0; k < 9; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_res[k] <= '0;
            end
            r_in_ready  <= 1'b1;
            r_mm_enable <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        // Beats 0..8 land in A, beats 9..17 in B
                        for (int k = 0; k < 9; k++) begin
                            if (r_beat == 5'(k)) begin
                                r_a[k] <= bus.in_data;
                            end
                            if (r_beat == c_B_BASE + 5'(k)) begin
                                r_b[k] <= bus.in_data;
                            end
                        end
                        if (r_beat == c_LAST_BEAT) begin
                            r_beat      <= 5'd0;
                            r_cyc       <= 8'd0;
                            r_state     <= S_COMPUTE;
                            r_in_ready  <= 1'b0;
                            r_mm_enable <= 1'b1;
                            r_busy      <= 1'b1;
                        end else begin
                            r_beat <= r_beat + 5'd1;
                        end
                    end
                end

                S_COMPUTE: begin
                    if (r_cyc == c_LAST_CYC) begin
                        // Products are settled by now; snapshot all nine
                        for (int k = 0; k < 9; k++) begin
                            r_res[k] <= w_c[k];
                        end
                        r_cyc       <= 8'd0;
                        r_idx       <= 4'd0;
                        r_out_data  <= w_c[0];
                        r_out_last  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_mm_enable <= 1'b0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_cyc <= r_cyc + 8'd1;
                    end
                end

                S_DRAIN: begin
                    if (w_out_fire) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_idx       <= 4'd0;
                            r_beat      <= 5'd0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= '0;
                            r_busy      <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_LOAD;
                        end else begin
                            // Preload the next element so out_data stays registered
                            r_idx      <= w_idx_nxt;
                            r_out_data <= r_res[w_idx_nxt];
                            r_out_last <= (w_idx_nxt == c_LAST_IDX);
                        end
                    end
                end

                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matmul_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_stream_ctrl
// Description : Self-checking bench for matmul_stream_ctrl with a behavioural
//               3x3 multiplier array and a result scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_matmul_stream_ctrl;

    localparam int BW  = 8;
    localparam int DW  = 2 * BW;
    localparam int LAT = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]       sb_q[$];
    logic [9*BW-1:0]     cur_a;
    logic [9*BW-1:0]     cur_b;
    logic [18*BW-1:0]    mm_c_model;

    always #5 clk = ~clk;

    matmul_stream_ctrl_if #(.BitWidth(BW)) u_if ();

    matmul_stream_ctrl #(
        .BitWidth (BW),
        .LATENCY  (LAT)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if.master)
    );

    // One element of C = A*B, wrapping at 2*BW bits
    function automatic logic [DW-1:0] mat_elem(input logic [9*BW-1:0] a,
                                               input logic [9*BW-1:0] b,
                                               input int e);
        logic [DW-1:0] acc;
        int r;
        int c;
        r   = e / 3;
        c   = e % 3;
        acc = '0;
        for (int k = 0; k < 3; k++) begin
            acc = acc + DW'(a[(r*3+k)*BW +: BW]) * DW'(b[(k*3+c)*BW +: BW]);
        end
        return acc;
    endfunction

    // Behavioural multiplier array fed from the controller's operand lanes
    always_comb begin
        mm_c_model = '0;
        for (int e = 0; e < 9; e++) begin
            mm_c_model[e*DW +: DW] = mat_elem(u_if.mm_a, u_if.mm_b, e);
        end
    end
    assign u_if.mm_c = mm_c_model;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready",  96'(u_if.in_ready),  96'd1);
        chk("rst_mm_enable", 96'(u_if.mm_enable), 96'd0);
        chk("rst_out_valid", 96'(u_if.out_valid), 96'd0);
        chk("rst_out_last",  96'(u_if.out_last),  96'd0);
        chk("rst_busy",      96'(u_if.busy),      96'd0);
        chk("rst_out_data",  96'(u_if.out_data),  96'd0);
        chk("rst_mm_a",      96'(u_if.mm_a),      96'd0);
        chk("rst_mm_b",      96'(u_if.mm_b),      96'd0);
    endtask

    // Stream 18 operand beats, optionally with an idle cycle before each beat
    task automatic load_txn(input logic [9*BW-1:0] a, input logic [9*BW-1:0] b, input bit gaps);
        for (int beat = 0; beat < 18; beat++) begin
            if (gaps) begin
                u_if.in_valid = 1'b0;
                @(negedge clk);
                chk("gap_in_ready", 96'(u_if.in_ready), 96'd1);
                chk("gap_busy",     96'(u_if.busy),     96'd0);
            end
            u_if.in_valid = 1'b1;
            u_if.in_data  = (beat < 9) ? a[beat*BW +: BW] : b[(beat-9)*BW +: BW];
            chk("load_in_ready", 96'(u_if.in_ready), 96'd1);
            @(negedge clk);
        end
        u_if.in_valid = 1'b0;
        u_if.in_data  = '0;
        cur_a = a;
        cur_b = b;
        for (int e = 0; e < 9; e++) begin
            sb_q.push_back(mat_elem(a, b, e));
        end
        chk("cmp_in_ready",  96'(u_if.in_ready),  96'd0);
        chk("cmp_busy",      96'(u_if.busy),      96'd1);
        chk("cmp_mm_enable", 96'(u_if.mm_enable), 96'd1);
    endtask

    // Count enable cycles and confirm the operand lanes stay put
    task automatic compute_phase();
        int en_cnt = 0;
        int guard  = 0;
        while (!u_if.out_valid && guard < 600) begin
            if (u_if.mm_enable) begin
                en_cnt++;
                chk("cmp_mm_a", 96'(u_if.mm_a), 96'(cur_a));
                chk("cmp_mm_b", 96'(u_if.mm_b), 96'(cur_b));
            end
            @(negedge clk);
            guard++;
        end
        chk("result_valid_seen", 96'(u_if.out_valid), 96'd1);
        chk("mm_enable_cycles",  96'(en_cnt),         96'(LAT));
        chk("drain_mm_enable",   96'(u_if.mm_enable), 96'd0);
    endtask

    // Pull nine results, with out_ready toggling when bp is set
    task automatic drain(input bit bp);
        int got   = 0;
        int guard = 0;
        bit ph    = 1'b0;
        while (got < 9 && guard < 200) begin
            u_if.out_ready = bp ? ph : 1'b1;
            ph = ~ph;
            if (u_if.out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("extra_beat", 96'(u_if.out_valid), 96'd0);
                end else begin
                    chk("out_data", 96'(u_if.out_data), 96'(sb_q[0]));
                    chk("out_last", 96'(u_if.out_last), 96'(got == 8));
                    chk("drain_busy", 96'(u_if.busy), 96'd1);
                    if (u_if.out_ready) begin
                        void'(sb_q.pop_front());
                        got++;
                    end
                end
            end
            @(negedge clk);
            guard++;
        end
        chk("beat_count",      96'(got),            96'd9);
        chk("post_in_ready",   96'(u_if.in_ready),  96'd1);
        chk("post_out_valid",  96'(u_if.out_valid), 96'd0);
        chk("post_busy",       96'(u_if.busy),      96'd0);
        chk("retain_mm_a",     96'(u_if.mm_a),      96'(cur_a));
        chk("retain_mm_b",     96'(u_if.mm_b),      96'(cur_b));
    endtask

    function automatic logic [9*BW-1:0] rand_mat();
        logic [9*BW-1:0] m;
        for (int k = 0; k < 9; k++) begin
            m[k*BW +: BW] = BW'($urandom_range(0, 255));
        end
        return m;
    endfunction

    initial begin
        logic [9*BW-1:0] a_m;
        logic [9*BW-1:0] b_m;

        u_if.in_valid  = 1'b0;
        u_if.in_data   = '0;
        u_if.out_ready = 1'b0;
        cur_a = '0;
        cur_b = '0;

        // Power-on reset
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs();
        reset_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs();

        // Identity times 1..9
        a_m = '0;
        b_m = '0;
        for (int k = 0; k < 9; k++) begin
            b_m[k*BW +: BW] = BW'(k + 1);
        end
        a_m[0*BW +: BW] = 8'd1;
        a_m[4*BW +: BW] = 8'd1;
        a_m[8*BW +: BW] = 8'd1;
        load_txn(a_m, b_m, 1'b0);
        compute_phase();
        drain(1'b0);

        // Full-scale operands wrap to 64003
        a_m = '1;
        b_m = '1;
        load_txn(a_m, b_m, 1'b0);
        compute_phase();
        chk("overflow_c00", 96'(u_if.out_data), 96'd64003);
        drain(1'b0);

        // Result backpressure
        load_txn(rand_mat(), rand_mat(), 1'b0);
        compute_phase();
        drain(1'b1);
        u_if.out_ready = 1'b1;

        // Operand gaps
        load_txn(rand_mat(), rand_mat(), 1'b1);
        compute_phase();
        drain(1'b0);

        // Reset in the third compute cycle
        load_txn(rand_mat(), rand_mat(), 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        sb_q.delete();
        cur_a = '0;
        cur_b = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        load_txn(rand_mat(), rand_mat(), 1'b0);
        compute_phase();
        drain(1'b0);

        // Back-to-back transactions
        load_txn(rand_mat(), rand_mat(), 1'b0);
        compute_phase();
        drain(1'b0);
        load_txn(rand_mat(), rand_mat(), 1'b0);
        compute_phase();
        drain(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
